// File: rtl/apb_master_bridge.sv
// APB initiator: turns a valid/ready command port into APB SETUP/ACCESS transfers
// and returns a one-cycle response pulse carrying read data and error status.
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The terminating edge is the one that would move the counter onto TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            r_state, w_state;
  logic              r_psel, w_psel;
  logic              r_penable, w_penable;
  logic              r_pwrite, w_pwrite;
  logic [ADDR_W-1:0] r_paddr, w_paddr;
  logic [DATA_W-1:0] r_pwdata, w_pwdata;
  logic              r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic              r_rsp_err, w_rsp_err;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic              w_accept;
  logic              w_timeout_hit;

  assign cmd_ready     = !rst && ((r_state == ST_IDLE) || ((r_state == ST_ACCESS) && pready));
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_timeout_hit = (TIMEOUT > 0) && (r_cnt == CNT_LAST);

  // State register and all registered bus/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_cnt       <= w_cnt;
    end
  end

  // Next-state and next-output logic for the SETUP/ACCESS sequence.
  always_comb begin
    w_state     = r_state;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
    w_cnt       = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_pwrite  = cmd_write;
          w_paddr   = cmd_addr;
          w_pwdata  = cmd_wdata;
          w_psel    = 1'b1;
          w_penable = 1'b0;
          w_state   = ST_SETUP;
        end else begin
          w_psel    = 1'b0;
          w_penable = 1'b0;
        end
      end
      ST_SETUP: begin
        w_penable = 1'b1;
        w_cnt     = '0;
        w_state   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          w_rsp_valid = 1'b1;
          w_rsp_err   = pslverr;
          w_rsp_rdata = r_pwrite ? {DATA_W{1'b0}} : prdata;
          // A command accepted on the completion edge chains straight into SETUP.
          if (w_accept) begin
            w_pwrite  = cmd_write;
            w_paddr   = cmd_addr;
            w_pwdata  = cmd_wdata;
            w_psel    = 1'b1;
            w_penable = 1'b0;
            w_state   = ST_SETUP;
          end else begin
            w_psel    = 1'b0;
            w_penable = 1'b0;
            w_state   = ST_IDLE;
          end
        end else if (w_timeout_hit) begin
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_rdata = '0;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_state     = ST_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_psel    = 1'b0;
        w_penable = 1'b0;
        w_state   = ST_IDLE;
      end
    endcase
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model with its own memory.
module tb_apb_master_bridge;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata = '0;
  logic              pready = 1'b1, pslverr = 1'b0;

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stimulus requested for the next cycle
  logic              d_valid = 1'b0, d_write = 1'b0, d_pready = 1'b1, d_pslverr = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;

  // slave memory (driven from the DUT bus) and model memory (driven from commands)
  logic [DATA_W-1:0] smem [256];
  logic [DATA_W-1:0] mmem [256];

  // transaction-level model: transfer in flight, its age in bus cycles, stalled ACCESS cycles
  logic              m_busy = 1'b0;
  int                m_age = 0;
  int                m_waits = 0;
  logic              m_write = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic              m_ready = 1'b0;
  logic              m_acc_last = 1'b0;
  logic              e_rv = 1'b0, e_err = 1'b0;
  logic [DATA_W-1:0] e_rdata = '0;

  // observation
  int                cyc = 0, acc_cyc = 0, rsp_cyc = 0;
  int                n_psel = 0, n_pen = 0, n_psel_lo = 0;
  logic              rsp_seen = 1'b0;
  logic [DATA_W-1:0] last_rdata = '0;
  logic              last_err = 1'b0;
  logic [DATA_W:0]   obs_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_waits = 0;
    m_write = 1'b0; m_addr = '0; m_wdata = '0;
    e_rv = 1'b0; e_err = 1'b0; e_rdata = '0;
  endtask

  task automatic model_start();
    m_busy = 1'b1; m_age = 1;
    m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
  endtask

  // Advance the model across one rising edge using the inputs held in that cycle.
  task automatic model_step();
    logic acc;
    logic nrv;
    acc = cmd_valid && m_ready;
    nrv = 1'b0;
    if (!m_busy) begin
      if (acc) model_start();
    end else if (m_age == 1) begin
      m_age = 2; m_waits = 0;
    end else if (pready) begin
      nrv = 1'b1; e_err = pslverr;
      e_rdata = m_write ? '0 : mmem[m_addr];
      if (m_write && !pslverr) mmem[m_addr] = m_wdata;
      if (acc) model_start();
      else m_busy = 1'b0;
    end else if (TIMEOUT != 0 && m_waits + 1 == TIMEOUT) begin
      nrv = 1'b1; e_err = 1'b1; e_rdata = '0; m_busy = 1'b0;
    end else begin
      m_waits++;
    end
    e_rv = nrv;
  endtask

  // One clock cycle: drive, compare against the model, act as slave, advance the model.
  task automatic cycle();
    @(negedge clk);
    cmd_valid = d_valid; cmd_write = d_write; cmd_addr = d_addr; cmd_wdata = d_wdata;
    pready = d_pready; pslverr = d_pslverr;
    prdata = smem[paddr];
    #1;
    m_ready = !m_busy || (m_age == 2 && pready);
    chk("cmd_ready", cmd_ready, m_ready);
    chk("psel", psel, m_busy);
    chk("penable", penable, m_busy && m_age == 2);
    chk("pwrite", pwrite, m_write);
    chk("paddr", paddr, m_addr);
    chk("pwdata", pwdata, m_wdata);
    chk("rsp_valid", rsp_valid, e_rv);
    if (e_rv) begin
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err", rsp_err, e_err);
    end
    if (rsp_valid) begin
      obs_q.push_back({rsp_err, rsp_rdata});
      rsp_seen = 1'b1; rsp_cyc = cyc; last_rdata = rsp_rdata; last_err = rsp_err;
    end
    if (psel) n_psel++; else n_psel_lo++;
    if (penable) n_pen++;
    if (psel && penable && pready && pwrite && !pslverr) smem[paddr] = pwdata;
    m_acc_last = cmd_valid && m_ready;
    if (m_acc_last) acc_cyc = cyc;
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  task automatic do_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    d_valid = 1'b1; d_write = w; d_addr = a; d_wdata = d;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!m_acc_last && n < 60);
    if (!m_acc_last) chk("accept_timeout", 64'd0, 64'd1);
    d_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n;
    rsp_seen = 1'b0;
    n = 0;
    while (!rsp_seen && n < budget) begin
      cycle();
      n++;
    end
    if (!rsp_seen) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int first_acc;
    int stall;
    for (int i = 0; i < 256; i++) begin
      smem[i] = '0; mmem[i] = '0;
    end

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_paddr", paddr, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // write then read, zero-wait slave
    d_pready = 1'b1;
    do_cmd(1'b1, 8'h32, 32'h61);
    n_psel = 0; n_pen = 0;
    wait_rsp(10);
    chk("wr_latency", rsp_cyc - acc_cyc, 3);
    chk("wr_psel_cycles", n_psel, 2);
    chk("wr_penable_cycles", n_pen, 1);
    do_cmd(1'b0, 8'h32, 32'h0);
    wait_rsp(10);
    chk("rd_latency", rsp_cyc - acc_cyc, 3);
    chk("rd_data_literal", last_rdata, 32'h61);
    chk("rd_err_literal", last_err, 1'b0);

    // back-to-back
    obs_q.delete();
    do_cmd(1'b1, 8'hfe, 32'h31);
    first_acc = acc_cyc;
    n_psel_lo = 0;
    do_cmd(1'b1, 8'hff, 32'h32);
    do_cmd(1'b0, 8'hfe, 32'h0);
    do_cmd(1'b0, 8'hff, 32'h0);
    chk("b2b_no_idle", n_psel_lo, 0);
    chk("b2b_spacing", acc_cyc - first_acc, 6);
    for (int i = 0; i < 10 && obs_q.size() < 4; i++) cycle();
    chk("b2b_rsp_count", obs_q.size(), 4);
    if (obs_q.size() >= 4) begin
      chk("b2b_rd_fe", obs_q[2], {1'b0, 32'h31});
      chk("b2b_rd_ff", obs_q[3], {1'b0, 32'h32});
    end

    // three wait states on a read
    smem[8'h10] = 32'hA5A5_0001; mmem[8'h10] = 32'hA5A5_0001;
    d_pready = 1'b0;
    do_cmd(1'b0, 8'h10, 32'h0);
    n_pen = 0;
    repeat (4) cycle();
    d_pready = 1'b1;
    wait_rsp(5);
    chk("ws_penable_cycles", n_pen, 4);
    chk("ws_rdata_literal", last_rdata, 32'hA5A5_0001);

    // PSLVERR on a write, then a normal command
    d_pslverr = 1'b1;
    do_cmd(1'b1, 8'h40, 32'h1234);
    wait_rsp(10);
    chk("slverr_err", last_err, 1'b1);
    d_pslverr = 1'b0;
    do_cmd(1'b0, 8'h40, 32'h0);
    wait_rsp(10);
    chk("after_slverr_err", last_err, 1'b0);
    chk("after_slverr_rdata", last_rdata, 32'h0);

    // pready on the 16th ACCESS cycle completes normally
    smem[8'h11] = 32'h0BAD_F00D; mmem[8'h11] = 32'h0BAD_F00D;
    d_pready = 1'b0;
    do_cmd(1'b0, 8'h11, 32'h0);
    n_pen = 0;
    repeat (16) cycle();
    d_pready = 1'b1;
    wait_rsp(3);
    chk("edge16_err", last_err, 1'b0);
    chk("edge16_rdata", last_rdata, 32'h0BAD_F00D);
    chk("edge16_penable_cycles", n_pen, 16);

    // timeout with pready stuck low, then recovery
    d_pready = 1'b0;
    do_cmd(1'b0, 8'h10, 32'h0);
    n_psel = 0; n_pen = 0;
    wait_rsp(40);
    chk("to_psel_cycles", n_psel, 17);
    chk("to_penable_cycles", n_pen, 16);
    chk("to_err", last_err, 1'b1);
    chk("to_rdata", last_rdata, 32'h0);
    d_pready = 1'b1;
    do_cmd(1'b0, 8'h10, 32'h0);
    wait_rsp(10);
    chk("to_recover_err", last_err, 1'b0);
    chk("to_recover_rdata", last_rdata, 32'hA5A5_0001);

    // reset in the ACCESS cycle of a write
    d_pready = 1'b0;
    do_cmd(1'b1, 8'h55, 32'hDEAD_BEEF);
    cycle();
    @(negedge clk);
    cmd_valid = 1'b0; pready = 1'b0; d_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_psel", psel, 1'b0);
    chk("mid_rst_penable", penable, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_hold_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_pwdata", pwdata, 32'h0);
    chk("post_rst_paddr", paddr, 8'h00);
    d_pready = 1'b1;
    cycle();

    // random traffic
    stall = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!(d_valid && !m_acc_last)) begin
        d_valid = ($urandom_range(0, 3) != 0);
        d_write = $urandom_range(0, 1) == 1;
        d_addr  = ADDR_W'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      if (stall == 0 && $urandom_range(0, 59) == 0) stall = 20;
      if (stall > 0) begin
        d_pready = 1'b0;
        stall--;
      end else begin
        d_pready = ($urandom_range(0, 3) != 0);
      end
      d_pslverr = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
RTL APB initiator that is the counterpart to apb_slave. It converts a simple valid/ready command port into APB SETUP/ACCESS transfers and returns a one-cycle response pulse carrying read data and error status. It supports PREADY wait states, PSLVERR, a programmable ACCESS-phase timeout, and back-to-back transfers with no IDLE gap.

Parameters:
ADDR_W, 8, width of paddr and cmd_addr
DATA_W, 32, width of pwdata, prdata, cmd_wdata, rsp_rdata
TIMEOUT, 16, max ACCESS cycles without pready before forced termination; 0 disables the timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted on edge where cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse, transfer finished
rsp_rdata  out  DATA_W  read data (0 for writes, timeouts)
rsp_err  out  1  pslverr or timeout, valid with rsp_valid
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready (tie 1 for zero-wait slaves)
pslverr  in  1  APB error (tie 0 if unused)

Behaviour:
- Reset (async assert, sync release): state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all 0; timeout counter 0. cmd_ready=0 while rst=1.
- All APB outputs and response outputs are registered. cmd_ready is combinational from state and pready.
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. On accept, latch pwrite/paddr/pwdata and go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0. Next state is ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata stay stable. The counter increments each cycle pready=0.
- Completion: an edge in ACCESS with pready=1. rsp_valid=1 for the following cycle. rsp_rdata = prdata sampled at that edge for reads, 0 for writes. rsp_err = pslverr sampled at that edge.
- After completion: if cmd_valid is also high on the completion edge (cmd_ready=1 in ACCESS when pready=1), latch the new command and go directly to SETUP. psel stays 1 and penable drops to 0, per APB back-to-back. Otherwise go to IDLE with psel=0 and penable=0.
- Timeout (TIMEOUT>0): on the edge where the counter reaches TIMEOUT with pready still 0, terminate. psel=0, penable=0, state=IDLE, rsp_valid pulse with rsp_err=1 and rsp_rdata=0. cmd_ready stays 0 on that edge. pready arriving on that same edge counts as normal completion, not timeout.
- Counter clears on entry to ACCESS. Counter width is clog2(TIMEOUT+1).
- Latency, zero-wait slave: cmd accepted at edge N → SETUP in cycle N+1 → ACCESS in N+2 → rsp_valid in N+3. Back-to-back throughput is one transfer per 2 cycles.
- The command port is ignored outside IDLE and the completion edge. cmd_valid with cmd_ready=0 has no effect; the source holds the command.
- Reset mid-transfer: psel/penable drop immediately (asynchronously), no rsp_valid is issued, and the transfer is lost.
- paddr/pwdata retain their last values in IDLE. pwdata is driven with the latched value for reads too; don't-care on the bus.

Test Plan:
- Write addr 0x32 data 0x61 then read 0x32 against apb_slave (pready=1) → the read returns rsp_rdata=0x61 with rsp_err=0. Each transfer shows 1 SETUP + 1 ACCESS cycle, and rsp_valid appears 3 cycles after accept.
- Back-to-back: cmd_valid held, writes 0xfe←0x31 then 0xff←0x32, then reads of both → no IDLE cycle between transfers (psel stays 1), and reads return 0x31 and 0x32.
- Wait states: slave holds pready=0 for 3 ACCESS cycles on a read of 0xA5A5_0001 → penable high for 4 cycles, paddr stable throughout, and rsp_rdata=0xA5A5_0001.
- PSLVERR: write with pslverr=1 on the completion edge → rsp_valid with rsp_err=1, and the next command is accepted normally.
- Timeout with TIMEOUT=16 and pready stuck 0 → psel drops after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, and a following command completes normally once pready is restored.
- Assert rst in the ACCESS cycle of a write → psel=0 and penable=0 immediately, no rsp_valid, and after release cmd_ready=1 with all outputs at their reset values.
